// File: rtl/sbox_table_loader.sv
// Streams 32 bytes into one S-box table as 64 nibble writes on the shared
// edit bus. Every output is a register loaded from the next-state decode.
module sbox_table_loader #(
  parameter int NUM_SBOX = 8,
  parameter bit HI_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] cfg_sbox,
  input  logic       abort,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       edit_sbox,
  output logic [3:0] new_sbox_val,
  output logic [2:0] sbox_sel,
  output logic [1:0] row_sel,
  output logic [3:0] col_sel,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_BYTE = 3'd1;
  localparam logic [2:0] WR_A      = 3'd2;
  localparam logic [2:0] WR_B      = 3'd3;
  localparam logic [2:0] FINISH    = 3'd4;

  logic [2:0] state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [3:0] nib2_q;
  logic       s_ready_q, edit_q, busy_q, done_q, err_q;
  logic [3:0] val_q, col_q;
  logic [2:0] sel_q;
  logic [1:0] row_q;

  logic accept, bad_cfg, go;
  logic [3:0] nib_first, nib_second;

  assign accept     = (state_q == WAIT_BYTE) && s_valid && s_ready_q;
  assign bad_cfg    = {1'b0, cfg_sbox} >= 4'(NUM_SBOX);
  assign go         = (state_q == IDLE) && start && !abort && !bad_cfg;
  assign nib_first  = HI_FIRST ? s_data[7:4] : s_data[3:0];
  assign nib_second = HI_FIRST ? s_data[3:0] : s_data[7:4];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = WAIT_BYTE;
        idx_d   = '0;
      end
      WAIT_BYTE: if (accept) state_d = WR_A;
      WR_A:      state_d = WR_B;
      // The entry being presented this cycle is the one in row/col.
      WR_B:      state_d = ({row_q, col_q} == 6'd63) ? FINISH : WAIT_BYTE;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      nib2_q    <= '0;
      s_ready_q <= 1'b0;
      edit_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      val_q     <= '0;
      sel_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      s_ready_q <= (state_d == WAIT_BYTE);
      edit_q    <= (state_d == WR_A) || (state_d == WR_B);
      busy_q    <= (state_d == WAIT_BYTE) || (state_d == WR_A) || (state_d == WR_B);
      done_q    <= (state_d == FINISH);
      err_q     <= (state_q == IDLE) && start && !abort && bad_cfg;
      if (go) sel_q <= cfg_sbox;
      if (accept) nib2_q <= nib_second;
      if (state_d == WR_A || state_d == WR_B) begin
        {row_q, col_q} <= idx_q;
        idx_q          <= idx_q + 6'd1;
        val_q          <= (state_d == WR_A) ? nib_first : nib2_q;
      end
    end
  end

  assign s_ready      = s_ready_q;
  assign edit_sbox    = edit_q;
  assign new_sbox_val = val_q;
  assign sbox_sel     = sel_q;
  assign row_sel      = row_q;
  assign col_sel      = col_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule
